// File: rtl/config_frame_writer_if.sv
// Bus between the bitstream source and the frame writer: the word stream in,
// plus the frame-register load signals and status going out to the tile columns.
interface config_frame_writer_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int RowSelectWidth  = 5
);
  logic [FrameBitsPerRow-1:0] WriteData;
  logic                       WriteStrobe;
  logic [31:0]                FrameAddressRegister;
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [RowSelectWidth-1:0]  RowSelect;
  logic                       FrameStrobe;
  logic                       LongFrameStrobe;
  logic                       ConfigActive;

  modport master (
    output WriteData, WriteStrobe,
    input  FrameAddressRegister, FrameData, RowSelect,
           FrameStrobe, LongFrameStrobe, ConfigActive
  );

  modport slave (
    input  WriteData, WriteStrobe,
    output FrameAddressRegister, FrameData, RowSelect,
           FrameStrobe, LongFrameStrobe, ConfigActive
  );
endinterface

// File: rtl/config_frame_writer.sv
// Configuration frame writer: locks onto the sync word, then splits the word
// stream into frame address words and per-row frame data loads.
//
//   state | meaning
//   IDLE  | waiting for SyncWord, other words discarded
//   ADDR  | next strobed word is a frame address (or desync)
//   DATA  | loading rows NumberOfRows-1 down to 0 of the current frame
module config_frame_writer #(
  parameter int                         NumberOfRows    = 16,
  parameter int                         RowSelectWidth  = 5,
  parameter int                         FrameBitsPerRow = 32,
  parameter int                         DesyncFlag      = 20,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
  input logic                   CLK,
  input logic                   reset,
  config_frame_writer_if.slave  cfg
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [RowSelectWidth-1:0] ROW_LAST = RowSelectWidth'(NumberOfRows - 1);

  state_t                     state, state_nxt;
  logic [RowSelectWidth-1:0]  row_cnt, row_cnt_nxt;
  logic [31:0]                frame_addr, frame_addr_nxt;
  logic [FrameBitsPerRow-1:0] frame_data, frame_data_nxt;
  logic [RowSelectWidth-1:0]  row_sel, row_sel_nxt;
  logic                       frame_stb, frame_stb_nxt;
  logic                       long_pend, long_pend_nxt;
  logic                       long_stb;
  logic                       active, active_nxt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      row_cnt    <= '0;
      frame_addr <= '0;
      frame_data <= '0;
      row_sel    <= '0;
      frame_stb  <= 1'b0;
      long_pend  <= 1'b0;
      long_stb   <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_cnt    <= row_cnt_nxt;
      frame_addr <= frame_addr_nxt;
      frame_data <= frame_data_nxt;
      row_sel    <= row_sel_nxt;
      frame_stb  <= frame_stb_nxt;
      long_pend  <= long_pend_nxt;
      // delayed one cycle so the long strobe trails the row-0 FrameStrobe
      long_stb   <= long_pend;
      active     <= active_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    row_cnt_nxt    = row_cnt;
    frame_addr_nxt = frame_addr;
    frame_data_nxt = frame_data;
    row_sel_nxt    = row_sel;
    frame_stb_nxt  = 1'b0;
    long_pend_nxt  = 1'b0;
    active_nxt     = active;
    if (cfg.WriteStrobe) begin
      case (state)
        IDLE: begin
          if (cfg.WriteData == SyncWord) begin
            state_nxt  = ADDR;
            active_nxt = 1'b1;
          end
        end
        ADDR: begin
          if (cfg.WriteData[DesyncFlag]) begin
            state_nxt  = IDLE;
            active_nxt = 1'b0;
          end else begin
            frame_addr_nxt = 32'(cfg.WriteData);
            row_cnt_nxt    = ROW_LAST;
            state_nxt      = DATA;
          end
        end
        DATA: begin
          frame_data_nxt = cfg.WriteData;
          row_sel_nxt    = row_cnt;
          frame_stb_nxt  = 1'b1;
          if (row_cnt == '0) begin
            state_nxt     = ADDR;
            long_pend_nxt = 1'b1;
          end else begin
            row_cnt_nxt = row_cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cfg.FrameAddressRegister = frame_addr;
  assign cfg.FrameData            = frame_data;
  assign cfg.RowSelect            = row_sel;
  assign cfg.FrameStrobe          = frame_stb;
  assign cfg.LongFrameStrobe      = long_stb;
  assign cfg.ConfigActive         = active;

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: a vector table for single-cycle
// behaviour plus hand-written full-frame sequences.
module tb_config_frame_writer;

  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'h0010_0000;

  logic CLK;
  logic reset;

  config_frame_writer_if #(.FrameBitsPerRow(32), .RowSelectWidth(5)) cfg ();

  config_frame_writer dut (
    .CLK   (CLK),
    .reset (reset),
    .cfg   (cfg.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        ws;
    logic [31:0] wd;
    logic [31:0] fa;
    logic [31:0] fd;
    logic [4:0]  rs;
    logic        fs;
    logic        lfs;
    logic        ca;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // drive on the falling edge, sample just after the rising edge
  task automatic step(input logic rst, input logic ws, input logic [31:0] wd);
    @(negedge CLK);
    reset            = rst;
    cfg.WriteStrobe  = ws;
    cfg.WriteData    = wd;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] fa, input logic [31:0] fd,
                         input logic [4:0] rs, input logic fs, input logic lfs, input logic ca);
    chk({tag, ".FrameAddressRegister"}, cfg.FrameAddressRegister, fa);
    chk({tag, ".FrameData"}, cfg.FrameData, fd);
    chk({tag, ".RowSelect"}, 32'(cfg.RowSelect), 32'(rs));
    chk({tag, ".FrameStrobe"}, 32'(cfg.FrameStrobe), 32'(fs));
    chk({tag, ".LongFrameStrobe"}, 32'(cfg.LongFrameStrobe), 32'(lfs));
    chk({tag, ".ConfigActive"}, 32'(cfg.ConfigActive), 32'(ca));
  endtask

  // Sends an address word then nwords data words, optionally with an idle
  // cycle after each word; data is base+i, except SYNC at index sync_idx.
  task automatic do_frame(input string tag, input logic [31:0] addr, input logic [31:0] base,
                          input bit gap, input int sync_idx, input int nwords, input logic addr_lfs);
    logic [31:0] d;
    step(1'b0, 1'b1, addr);
    chk({tag, ".addr.far"}, cfg.FrameAddressRegister, addr);
    chk({tag, ".addr.fs"}, 32'(cfg.FrameStrobe), 32'd0);
    chk({tag, ".addr.lfs"}, 32'(cfg.LongFrameStrobe), 32'(addr_lfs));
    chk({tag, ".addr.ca"}, 32'(cfg.ConfigActive), 32'd1);
    for (int i = 0; i < nwords; i++) begin
      d = (i == sync_idx) ? SYNC : base + 32'(i);
      step(1'b0, 1'b1, d);
      chk({tag, ".fs"}, 32'(cfg.FrameStrobe), 32'd1);
      chk({tag, ".rs"}, 32'(cfg.RowSelect), 32'(15 - i));
      chk({tag, ".fd"}, cfg.FrameData, d);
      chk({tag, ".lfs"}, 32'(cfg.LongFrameStrobe), 32'd0);
      if (gap) begin
        step(1'b0, 1'b0, 32'hDEAD_BEEF);
        chk({tag, ".gap.fs"}, 32'(cfg.FrameStrobe), 32'd0);
        chk({tag, ".gap.rs"}, 32'(cfg.RowSelect), 32'(15 - i));
        chk({tag, ".gap.fd"}, cfg.FrameData, d);
        chk({tag, ".gap.lfs"}, 32'(cfg.LongFrameStrobe), 32'(i == 15));
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    cfg.WriteStrobe = 1'b0;
    cfg.WriteData   = '0;

    //           rst   ws    wd             fa     fd     rs  fs lfs ca
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         32'h0, 32'h0,  0, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'h1234_5678, 32'h0, 32'h0,  0, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, SYNC,          32'h0, 32'h0,  0, 0, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         32'h0, 32'h0,  0, 0, 0, 1};
    vecs[4]  = '{1'b0, 1'b1, DESYNC,        32'h0, 32'h0,  0, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, SYNC,          32'h0, 32'h0,  0, 0, 0, 1};
    vecs[6]  = '{1'b0, 1'b1, 32'h3,         32'h3, 32'h0,  0, 0, 0, 1};
    vecs[7]  = '{1'b0, 1'b1, 32'hA0,        32'h3, 32'hA0, 15, 1, 0, 1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h3, 32'hA0, 15, 0, 0, 1};
    vecs[9]  = '{1'b1, 1'b1, SYNC,          32'h0, 32'h0,  0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b1, SYNC,          32'h0, 32'h0,  0, 0, 0, 1};
    vecs[11] = '{1'b0, 1'b1, DESYNC,        32'h0, 32'h0,  0, 0, 0, 0};

    for (int v = 0; v < 12; v++) begin
      step(vecs[v].rst, vecs[v].ws, vecs[v].wd);
      chk_all($sformatf("vec%0d", v), vecs[v].fa, vecs[v].fd, vecs[v].rs,
              vecs[v].fs, vecs[v].lfs, vecs[v].ca);
    end

    // full frame, back-to-back
    step(1'b0, 1'b1, SYNC);
    chk("s1.sync.ca", 32'(cfg.ConfigActive), 32'd1);
    do_frame("s1", 32'h3, 32'hA0, 1'b0, -1, 16, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("s1.end", 32'h3, 32'hAF, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    chk("s1.end2.lfs", 32'(cfg.LongFrameStrobe), 32'd0);

    // same frame with an idle cycle after every word
    do_frame("s2", 32'h3, 32'hA0, 1'b1, -1, 16, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("s2.end.lfs", 32'(cfg.LongFrameStrobe), 32'd0);

    // two frames back-to-back then desync
    do_frame("s3a", 32'h1, 32'hB0, 1'b0, -1, 16, 1'b0);
    do_frame("s3b", 32'h2, 32'hC0, 1'b0, -1, 16, 1'b1);
    step(1'b0, 1'b1, DESYNC);
    chk_all("s3.desync", 32'h2, 32'hCF, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, SYNC);
    chk("s3.resync.ca", 32'(cfg.ConfigActive), 32'd1);

    // SyncWord inside a frame is plain data
    do_frame("s4", 32'h4, 32'hD0, 1'b0, 5, 16, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("s4.end.lfs", 32'(cfg.LongFrameStrobe), 32'd1);

    // reset mid-frame wins over a simultaneous strobe
    do_frame("s5", 32'h5, 32'hE0, 1'b0, -1, 7, 1'b0);
    step(1'b1, 1'b1, 32'hE7);
    chk_all("s5.reset", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("s5.post.lfs", 32'(cfg.LongFrameStrobe), 32'd0);
    step(1'b0, 1'b1, 32'h3);
    step(1'b0, 1'b1, 32'hE0);
    chk_all("s5.ignored", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, SYNC);
    chk("s5.sync.ca", 32'(cfg.ConfigActive), 32'd1);
    step(1'b0, 1'b1, 32'h6);
    chk("s5.addr.far", cfg.FrameAddressRegister, 32'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
